ctrl_pipe_hazard: RTL and testbench



---
 rtl/ctrl_pipe_hazard.sv | 200 ++++++++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
// +--------------------------------------------------------------------------+
// | ctrl_pipe_hazard: ID/EX, EX/MEM, MEM/WB control pipeline, bubbles,        |
// | branch/jump flush and stall control. Option macro: CTRL_FWD_EN.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module ctrl_pipe_hazard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_reg_dst,
    input  logic             id_alu_src,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_bne,
    input  logic [1:0]       id_alu_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_bne,
    output logic [4:0]       ex_dest,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_mem_to_reg,
    output logic             mem_reg_write,
    output logic [4:0]       mem_dest,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_write,
    output logic [4:0]       wb_dest,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_src_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] c_REG_ZERO = 5'd0;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       bne;
        logic [4:0] dest;
    } idex_t;

    idex_t            idex_q, idex_d;
    logic             exmem_read_q, exmem_write_q, exmem_to_reg_q, exmem_reg_write_q;
    logic [4:0]       exmem_dest_q;
    logic             memwb_to_reg_q, memwb_reg_write_q;
    logic [4:0]       memwb_dest_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_taken, w_uses_rt, w_hit_ex, w_hazard, w_stall, w_bubble;

    assign w_taken   = idex_q.jump | (idex_q.branch & (ex_zero ^ idex_q.bne));
    assign w_uses_rt = id_valid & (~id_alu_src | id_mem_write);
    assign w_hit_ex  = idex_q.reg_write && (idex_q.dest != c_REG_ZERO) &&
                       ((id_valid && (id_rs == idex_q.dest)) ||
                        (w_uses_rt && (id_rt == idex_q.dest)));

`ifdef CTRL_FWD_EN
    logic [4:0] ex_rs_q, ex_rt_q;

    // Forwarding covers distance 1 and 2, so only a load in EX must wait.
    assign w_hazard = idex_q.mem_read & w_hit_ex;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        fwd_sel = 2'b00;
        if (exmem_reg_write_q && (exmem_dest_q != c_REG_ZERO) && (exmem_dest_q == src))
            fwd_sel = 2'b10;
        else if (memwb_reg_write_q && (memwb_dest_q != c_REG_ZERO) && (memwb_dest_q == src))
            fwd_sel = 2'b01;
    endfunction

    assign fwd_a = fwd_sel(ex_rs_q);
    assign fwd_b = fwd_sel(ex_rt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= w_bubble ? c_REG_ZERO : id_rs;
            ex_rt_q <= w_bubble ? c_REG_ZERO : id_rt;
        end
    end
`else
    logic w_hit_mem;

    // The register file writes in the first half-cycle, so WB never conflicts.
    assign w_hit_mem = exmem_reg_write_q && (exmem_dest_q != c_REG_ZERO) &&
                       ((id_valid && (id_rs == exmem_dest_q)) ||
                        (w_uses_rt && (id_rt == exmem_dest_q)));
    assign w_hazard  = w_hit_ex | w_hit_mem;
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif

    assign w_stall  = w_hazard & ~w_taken;
    assign w_bubble = ~id_valid | w_stall | w_taken;

    always_comb begin
        idex_d = '0;
        if (!w_bubble) begin
            idex_d.alu_src    = id_alu_src;
            idex_d.alu_op     = id_alu_op;
            idex_d.mem_read   = id_mem_read;
            idex_d.mem_write  = id_mem_write;
            idex_d.mem_to_reg = id_mem_to_reg;
            idex_d.reg_write  = id_reg_write;
            idex_d.branch     = id_branch;
            idex_d.jump       = id_jump;
            idex_d.bne        = id_bne;
            idex_d.dest       = id_reg_dst ? id_rd : id_rt;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q            <= '0;
            exmem_read_q      <= 1'b0;
            exmem_write_q     <= 1'b0;
            exmem_to_reg_q    <= 1'b0;
            exmem_reg_write_q <= 1'b0;
            exmem_dest_q      <= '0;
            memwb_to_reg_q    <= 1'b0;
            memwb_reg_write_q <= 1'b0;
            memwb_dest_q      <= '0;
            stall_cnt_q       <= '0;
        end else begin
            idex_q            <= idex_d;
            exmem_read_q      <= idex_q.mem_read;
            exmem_write_q     <= idex_q.mem_write;
            exmem_to_reg_q    <= idex_q.mem_to_reg;
            exmem_reg_write_q <= idex_q.reg_write;
            exmem_dest_q      <= idex_q.dest;
            memwb_to_reg_q    <= exmem_to_reg_q;
            memwb_reg_write_q <= exmem_reg_write_q;
            memwb_dest_q      <= exmem_dest_q;
            stall_cnt_q       <= stall_cnt_d;
        end
    end

    assign ex_alu_src     = idex_q.alu_src;
    assign ex_alu_op      = idex_q.alu_op;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_mem_to_reg  = idex_q.mem_to_reg;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_branch      = idex_q.branch;
    assign ex_jump        = idex_q.jump;
    assign ex_bne         = idex_q.bne;
    assign ex_dest        = idex_q.dest;
    assign mem_mem_read   = exmem_read_q;
    assign mem_mem_write  = exmem_write_q;
    assign mem_mem_to_reg = exmem_to_reg_q;
    assign mem_reg_write  = exmem_reg_write_q;
    assign mem_dest       = exmem_dest_q;
    assign wb_mem_to_reg  = memwb_to_reg_q;
    assign wb_reg_write   = memwb_reg_write_q;
    assign wb_dest        = memwb_dest_q;
    assign pc_write       = ~w_stall;
    assign ifid_write     = ~w_stall;
    assign ifid_flush     = w_taken;
    assign pc_src_taken   = w_taken;
    assign stall_cnt      = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_hazard.sv
// +--------------------------------------------------------------------------+
// | tb_ctrl_pipe_hazard: directed bench for ctrl_pipe_hazard (CNT_W=4).      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ctrl_pipe_hazard;

    localparam int CNT_W = 4;

`ifdef CTRL_FWD_EN
    localparam int EXP_LU = 1, EXP_D1 = 0, EXP_D2 = 0, EXP_F1 = 2, EXP_F2 = 1;
`else
    localparam int EXP_LU = 2, EXP_D1 = 2, EXP_D2 = 1, EXP_F1 = 0, EXP_F2 = 0;
`endif

    localparam int K_NONE = 0, K_R = 1, K_LW = 2, K_BEQ = 3, K_BNE = 4, K_J = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
    logic id_mem_read, id_mem_write, id_branch, id_jump, id_bne;
    logic [1:0] id_alu_op;
    logic [4:0] id_rs, id_rt, id_rd;
    logic ex_zero;
    logic ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic ex_branch, ex_jump, ex_bne;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
    logic wb_mem_to_reg, wb_reg_write;
    logic pc_write, ifid_write, ifid_flush, pc_src_taken;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    ctrl_pipe_hazard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_bne(id_bne), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_bne(ex_bne), .ex_dest(ex_dest),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_src_taken(pc_src_taken), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
         id_mem_write, id_branch, id_jump, id_bne} = '0;
        id_alu_op = 2'b00;
        id_valid  = (kind != K_NONE);
        id_rs = rs; id_rt = rt; id_rd = rd;
        case (kind)
            K_R:   begin id_reg_dst = 1'b1; id_reg_write = 1'b1; id_alu_op = 2'b10; end
            K_LW:  begin id_alu_src = 1'b1; id_mem_to_reg = 1'b1; id_reg_write = 1'b1;
                         id_mem_read = 1'b1; end
            K_BEQ: begin id_branch = 1'b1; id_alu_op = 2'b01; end
            K_BNE: begin id_branch = 1'b1; id_bne = 1'b1; id_alu_op = 2'b01; end
            K_J:   id_jump = 1'b1;
            default: begin
                {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
                 id_mem_write, id_branch, id_jump, id_bne} = 'x;
                id_alu_op = 'x; id_rs = 'x; id_rt = 'x; id_rd = 'x;
            end
        endcase
    endtask

    // Counts consecutive cycles with pc_write low while ID is held, bounded.
    task automatic count_stalls(input string tag, input int exp);
        int n;
        n = 0;
        while (pc_write !== 1'b1 && n < 8) begin
            chk({tag, "_ifid_write"}, ifid_write, 0);
            @(posedge clk);
            #3;
            n++;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ex_zero = 1'b0;
        set_id(K_NONE, 0, 0, 0);
        #2;
        chk("rst_ex_reg_write", ex_reg_write, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_ifid_flush", ifid_flush, 0);
        chk("rst_pc_src_taken", pc_src_taken, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        #10 rst_n = 1'b1;

        // R-type rd=5 travels ID -> EX -> MEM -> WB
        step(); set_id(K_R, 1, 2, 5); #2;
        chk("r_pc_write", pc_write, 1);
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("r_ex_reg_write", ex_reg_write, 1);
        chk("r_ex_dest", ex_dest, 5);
        chk("r_ex_alu_op", ex_alu_op, 2'b10);
        chk("r_mem_dest_early", mem_dest, 0);
        step(); #2;
        chk("r_mem_dest", mem_dest, 5);
        chk("r_mem_reg_write", mem_reg_write, 1);
        step(); #2;
        chk("r_wb_dest", wb_dest, 5);
        chk("r_wb_reg_write", wb_reg_write, 1);

        // LW r8 followed by ADD rs=r8
        step(); set_id(K_LW, 0, 8, 0); #2;
        chk("lw_pc_write", pc_write, 1);
        step(); set_id(K_R, 8, 9, 10); #2;
        chk("lw_ex_mem_read", ex_mem_read, 1);
        chk("lw_ex_alu_src", ex_alu_src, 1);
        chk("lw_ex_mem_to_reg", ex_mem_to_reg, 1);
        chk("lw_ex_dest", ex_dest, 8);
        chk("lu_pc_write", pc_write, 0);
        count_stalls("lu_stalls", EXP_LU);
        chk("lu_ex_bubble", ex_reg_write, 0);
        chk("lu_stall_cnt", stall_cnt, EXP_LU);
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("add_ex_dest", ex_dest, 10);
        chk("add_ex_reg_write", ex_reg_write, 1);

        // BEQ taken, then BNE with zero=1 (not taken) and zero=0 (taken)
        step(); set_id(K_BEQ, 0, 0, 0); #2;
        step(); set_id(K_R, 1, 2, 7); ex_zero = 1'b1; #2;
        chk("beq_ex_branch", ex_branch, 1);
        chk("beq_taken", pc_src_taken, 1);
        chk("beq_flush", ifid_flush, 1);
        chk("beq_pc_write", pc_write, 1);
        step(); set_id(K_BNE, 0, 0, 0); ex_zero = 1'b0; #2;
        chk("beq_bubble_reg_write", ex_reg_write, 0);
        chk("beq_bubble_dest", ex_dest, 0);
        chk("beq_after_taken", pc_src_taken, 0);
        step(); set_id(K_NONE, 0, 0, 0); ex_zero = 1'b1; #2;
        chk("bne_z1_taken", pc_src_taken, 0);
        ex_zero = 1'b0; #1;
        chk("bne_z0_taken", pc_src_taken, 1);
        chk("bne_z0_flush", ifid_flush, 1);

        // J in EX while ID depends on the LW in MEM: flush wins
        step(); set_id(K_LW, 0, 11, 0); #2;
        step(); set_id(K_J, 0, 0, 0); #2;
        step(); set_id(K_R, 11, 0, 12); #2;
        chk("j_taken", pc_src_taken, 1);
        chk("j_pc_write", pc_write, 1);
        chk("j_ifid_write", ifid_write, 1);
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("j_stall_cnt", stall_cnt, EXP_LU);
        chk("j_ex_bubble", ex_reg_write, 0);
        chk("j_wb_mem_to_reg", wb_mem_to_reg, 1);
        chk("j_wb_dest", wb_dest, 11);

        // RAW at distance 1
        step(); set_id(K_R, 0, 0, 3); #2;
        step(); set_id(K_R, 3, 3, 4); #2;
        count_stalls("d1_stalls", EXP_D1);
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("d1_ex_dest", ex_dest, 4);
        chk("d1_fwd_a", fwd_a, EXP_F1);
        chk("d1_fwd_b", fwd_b, EXP_F1);

        // RAW at distance 2
        step(); set_id(K_R, 0, 0, 3); #2;
        step(); set_id(K_NONE, 0, 0, 0); #2;
        step(); set_id(K_R, 3, 0, 4); #2;
        count_stalls("d2_stalls", EXP_D2);
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("d2_fwd_a", fwd_a, EXP_F2);
        chk("d2_fwd_b", fwd_b, 0);

        // Writer of r0 never causes a stall or a forward
        step(); set_id(K_R, 0, 0, 0); #2;
        step(); set_id(K_R, 0, 0, 4); #2;
        count_stalls("r0_stalls", 0);
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("r0_fwd_a", fwd_a, 0);
        chk("total_stall_cnt", stall_cnt, EXP_LU + EXP_D1 + EXP_D2);

        // Asynchronous reset while LW sits in MEM
        step(); set_id(K_LW, 0, 8, 0); #2;
        step(); set_id(K_NONE, 0, 0, 0); #2;
        step(); #2;
        chk("rstmid_before", mem_mem_read, 1);
        rst_n = 1'b0; #1;
        chk("rstmid_mem_read", mem_mem_read, 0);
        chk("rstmid_stall_cnt", stall_cnt, 0);
        #1 rst_n = 1'b1;

        // Chain of dependent loads drives the stall counter into saturation
        for (int i = 0; i < 20; i++) begin
            int n;
            step(); set_id(K_LW, 1, 1, 0); #2;
            n = 0;
            while (pc_write !== 1'b1 && n < 8) begin
                @(posedge clk);
                #3;
                n++;
            end
            if (n >= 8) chk("sat_timeout", n, 0);
        end
        step(); set_id(K_NONE, 0, 0, 0); #2;
        chk("sat_stall_cnt", stall_cnt, {CNT_W{1'b1}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
